// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state codes, defaults and player-count clamp for the turn engine
// Purpose: constants and helpers imported by turn_engine_multi and turn_rotator.
// Contents:
//   PIC_W_DEF      default picture code width
//   ST_*           FSM state codes (3-bit)
//   clamp_players  limit a requested player count to 2..min(max_p, tiles-1)
package game_pkg;

   localparam int PIC_W_DEF = 4;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_FLIP = 3'd1;
   localparam logic [2:0] ST_CHECK     = 3'd2;
   localparam logic [2:0] ST_REVEAL    = 3'd3;
   localparam logic [2:0] ST_MOVE      = 3'd4;
   localparam logic [2:0] ST_NEXT      = 3'd5;
   localparam logic [2:0] ST_WON       = 3'd6;

   // Keeping the count below the ring length guarantees a free tile ahead.
   function automatic int clamp_players(input int n, input int max_p, input int tiles);
      int hi;
      hi = (max_p < tiles) ? max_p : tiles - 1;
      if (n < 2) return 2;
      if (n > hi) return hi;
      return n;
   endfunction

endpackage

// File: rtl/turn_rotator.sv
// rtl/turn_rotator.sv - current-player register with modulo-N advance
// Purpose: holds the index of the player owning the turn.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_i          force player 0 (game start)
//   advance_i       move to next player, wrapping at num_players_i
//   num_players_i   active player count
//   cur_player_o    player holding the turn
module turn_rotator
   import game_pkg::*;
#(
   parameter int MAX_PLAYERS = 4,
   parameter int PW          = $clog2(MAX_PLAYERS),
   parameter int NPW         = PW + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           init_i,
   input  logic           advance_i,
   input  logic [NPW-1:0] num_players_i,
   output logic [PW-1:0]  cur_player_o
);

   logic [PW-1:0]  cur_q, cur_d;
   logic [NPW-1:0] inc;

   always_comb begin
      inc   = {1'b0, cur_q} + NPW'(1);
      cur_d = cur_q;
      if (init_i)
         cur_d = '0;
      else if (advance_i)
         cur_d = (inc >= num_players_i) ? '0 : inc[PW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst)
         cur_q <= '0;
      else
         cur_q <= cur_d;
   end

   assign cur_player_o = cur_q;

endmodule

// File: rtl/turn_engine_multi.sv
// rtl/turn_engine_multi.sv - N-player chicken track turn engine (flip, compare, move / pass)
// Purpose: per accepted flip, compares the card picture with the first free tile ahead of
//   the current chicken; a match moves it (jumping occupied tiles) and keeps the turn,
//   a miss passes the turn. Detects the winner.
// Optional feature macro: REVEAL_TIMER_EN adds a REVEAL hold state and the reveal output.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, num_players          begin a game (IDLE/WON only), player count (clamped)
//   cfg_we/is_card/addr/data    picture table writes, IDLE only
//   flip_valid/card, flip_ready flip handshake
//   cur_player, tile_info       turn owner and its position
//   go, miss                    one-cycle outcome pulses
//   win, winner                 game won level and winning player
//   reveal                      (REVEAL_TIMER_EN only) high while card is shown
module turn_engine_multi
   import game_pkg::*;
#(
   parameter int MAX_PLAYERS = 4,
   parameter int NUM_TILES   = 24,
   parameter int NUM_CARDS   = 12,
   parameter int PIC_W       = PIC_W_DEF,
   parameter int WIN_STEPS   = 24,
   localparam int PW  = $clog2(MAX_PLAYERS),
   localparam int NPW = PW + 1,
   localparam int TW  = $clog2(NUM_TILES),
   localparam int CW  = $clog2(NUM_CARDS),
   localparam int SW  = $clog2(WIN_STEPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NPW-1:0]   num_players,
   input  logic             cfg_we,
   input  logic             cfg_is_card,
   input  logic [TW-1:0]    cfg_addr,
   input  logic [PIC_W-1:0] cfg_data,
   input  logic             flip_valid,
   input  logic [CW-1:0]    flip_card,
   output logic             flip_ready,
   output logic [PW-1:0]    cur_player,
   output logic [TW-1:0]    tile_info,
   output logic             go,
   output logic             miss,
   output logic             win,
   output logic [PW-1:0]    winner
`ifdef REVEAL_TIMER_EN
   ,
   output logic             reveal
`endif
);

   logic [2:0]       state_q, state_d;
   logic [TW-1:0]    pos_q   [MAX_PLAYERS];
   logic [SW-1:0]    steps_q [MAX_PLAYERS];
   logic [NPW-1:0]   nplay_q;
   logic [CW-1:0]    card_q;
   logic             bad_q;
   logic [TW-1:0]    target_q;
   logic [NPW-1:0]   dist_q;
   logic [PW-1:0]    winner_q;
   logic [PIC_W-1:0] tile_pic [NUM_TILES];
   logic [PIC_W-1:0] card_pic [NUM_CARDS];

   logic             start_ok;
   int               np_int;
   logic [TW-1:0]    start_pos [MAX_PLAYERS];
   logic [TW-1:0]    tgt_c;
   logic [NPW-1:0]   dist_c;
   logic             found, occ;
   int               t;
   logic             match_c;
   logic [SW:0]      step_sum;
   logic             reach_win;
   logic [SW-1:0]    step_sat;

   assign start_ok = start && (state_q == ST_IDLE || state_q == ST_WON);

   turn_rotator #(.MAX_PLAYERS(MAX_PLAYERS)) u_rot (
      .clk           (clk),
      .rst           (rst),
      .init_i        (start_ok),
      .advance_i     (state_q == ST_NEXT),
      .num_players_i (nplay_q),
      .cur_player_o  (cur_player)
   );

   // Evenly spaced starting tiles for the active players.
   always_comb begin
      np_int = clamp_players(int'(num_players), MAX_PLAYERS, NUM_TILES);
      for (int p = 0; p < MAX_PLAYERS; p++)
         start_pos[p] = (p < np_int) ? TW'(p * (NUM_TILES / np_int)) : '0;
   end

   // First tile ahead not held by another active chicken; at most MAX_PLAYERS away.
   always_comb begin
      tgt_c  = pos_q[cur_player];
      dist_c = '0;
      found  = 1'b0;
      occ    = 1'b0;
      t      = 0;
      for (int d = 1; d <= MAX_PLAYERS; d++) begin
         t   = (int'(pos_q[cur_player]) + d) % NUM_TILES;
         occ = 1'b0;
         for (int j = 0; j < MAX_PLAYERS; j++)
            if (j < int'(nplay_q) && j != int'(cur_player) && int'(pos_q[j]) == t)
               occ = 1'b1;
         if (!found && !occ) begin
            found  = 1'b1;
            tgt_c  = TW'(t);
            dist_c = NPW'(d);
         end
      end
      match_c = !bad_q && (card_pic[card_q] == tile_pic[tgt_c]);
   end

   always_comb begin
      step_sum  = {1'b0, steps_q[cur_player]} + (SW+1)'(dist_q);
      reach_win = step_sum >= (SW+1)'(WIN_STEPS);
      step_sat  = reach_win ? SW'(WIN_STEPS) : step_sum[SW-1:0];
   end

`ifdef REVEAL_TIMER_EN
   localparam int REVEAL_CYCLES = 50_000_000;
   localparam int RW            = $clog2(REVEAL_CYCLES);
   logic [RW-1:0] rev_cnt_q;
   logic          match_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rev_cnt_q <= '0;
         match_q   <= 1'b0;
      end else begin
         rev_cnt_q <= (state_q == ST_REVEAL) ? rev_cnt_q + RW'(1) : '0;
         if (state_q == ST_CHECK)
            match_q <= match_c;
      end
   end

   assign reveal = (state_q == ST_REVEAL);
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_WON: if (start) state_d = ST_WAIT_FLIP;
         ST_WAIT_FLIP:    if (flip_valid) state_d = ST_CHECK;
`ifdef REVEAL_TIMER_EN
         ST_CHECK:        state_d = ST_REVEAL;
         ST_REVEAL:       if (rev_cnt_q == RW'(REVEAL_CYCLES - 1))
                             state_d = match_q ? ST_MOVE : ST_NEXT;
`else
         ST_CHECK:        state_d = match_c ? ST_MOVE : ST_NEXT;
`endif
         ST_MOVE:         state_d = reach_win ? ST_WON : ST_WAIT_FLIP;
         ST_NEXT:         state_d = ST_WAIT_FLIP;
         default:         state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         nplay_q  <= '0;
         card_q   <= '0;
         bad_q    <= 1'b0;
         target_q <= '0;
         dist_q   <= '0;
         winner_q <= '0;
         for (int p = 0; p < MAX_PLAYERS; p++) begin
            pos_q[p]   <= '0;
            steps_q[p] <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE, ST_WON: if (start) begin
               nplay_q  <= NPW'(np_int);
               winner_q <= '0;
               for (int p = 0; p < MAX_PLAYERS; p++) begin
                  pos_q[p]   <= start_pos[p];
                  steps_q[p] <= '0;
               end
            end
            ST_WAIT_FLIP: if (flip_valid) begin
               card_q <= flip_card;
               bad_q  <= int'(flip_card) >= NUM_CARDS;
            end
            ST_CHECK: begin
               target_q <= tgt_c;
               dist_q   <= dist_c;
            end
            ST_MOVE: begin
               pos_q[cur_player]   <= target_q;
               steps_q[cur_player] <= step_sat;
               if (reach_win)
                  winner_q <= cur_player;
            end
            default: ;
         endcase
      end
   end

   // Picture tables are deliberately not reset so configuration survives rst.
   always_ff @(posedge clk) begin
      if (!rst && state_q == ST_IDLE && cfg_we) begin
         if (cfg_is_card) begin
            if (int'(cfg_addr[CW-1:0]) < NUM_CARDS)
               card_pic[cfg_addr[CW-1:0]] <= cfg_data;
         end else if (int'(cfg_addr) < NUM_TILES) begin
            tile_pic[cfg_addr] <= cfg_data;
         end
      end
   end

   assign flip_ready = (state_q == ST_WAIT_FLIP);
   assign tile_info  = pos_q[cur_player];
   assign go         = (state_q == ST_MOVE);
   assign miss       = (state_q == ST_NEXT);
   assign win        = (state_q == ST_WON);
   assign winner     = winner_q;

endmodule

// File: tb/tb_turn_engine_multi.sv
// tb/tb_turn_engine_multi.sv - directed scoreboard bench for turn_engine_multi
module tb_turn_engine_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] num_players = '0;
   logic       cfg_we = 1'b0;
   logic       cfg_is_card = 1'b0;
   logic [4:0] cfg_addr = '0;
   logic [3:0] cfg_data = '0;
   logic       flip_valid = 1'b0;
   logic [3:0] flip_card = '0;
   logic       flip_ready, go, miss, win;
   logic [1:0] cur_player, winner;
   logic [4:0] tile_info;
`ifdef REVEAL_TIMER_EN
   logic       reveal;
`endif

   turn_engine_multi dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_players (num_players),
      .cfg_we      (cfg_we),
      .cfg_is_card (cfg_is_card),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .flip_valid  (flip_valid),
      .flip_card   (flip_card),
      .flip_ready  (flip_ready),
      .cur_player  (cur_player),
      .tile_info   (tile_info),
      .go          (go),
      .miss        (miss),
      .win         (win),
      .winner      (winner)
`ifdef REVEAL_TIMER_EN
      ,
      .reveal      (reveal)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_go;
      logic [1:0] player;
      logic [4:0] tile;
      logic       won;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic card, input int addr, input int data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_is_card = card; cfg_addr = 5'(addr); cfg_data = 4'(data);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic start_game(input int n);
      @(negedge clk);
      start = 1'b1; num_players = 3'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic expect_evt(input logic g, input int p, input int t, input logic w);
      exp_t e;
      e.is_go = g; e.player = 2'(p); e.tile = 5'(t); e.won = w;
      sb.push_back(e);
   endtask

   task automatic flip(input int card);
      exp_t e;
      int   lat;
      logic seen;
      e = '0;
      @(negedge clk);
      flip_valid = 1'b1; flip_card = 4'(card);
      lat = 0;
      while (flip_ready !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("flip_ready", 32'(flip_ready), 32'(1));
      @(negedge clk);
      flip_valid = 1'b0;
      lat  = 1;
      seen = 1'b0;
      while (!seen && lat < 10) begin
         if (go === 1'b1 || miss === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      check("latency", 32'(lat), 32'(2));
      check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) e = sb.pop_front();
      check("go", 32'(go), 32'(e.is_go));
      check("miss", 32'(miss), 32'(!e.is_go));
      @(negedge clk);
      check("pulse_len", 32'(go | miss), 32'(0));
      check("cur_player", 32'(cur_player), 32'(e.player));
      check("tile_info", 32'(tile_info), 32'(e.tile));
      check("win", 32'(win), 32'(e.won));
      if (e.won) check("winner", 32'(winner), 32'(e.player));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_flip_ready", 32'(flip_ready), 32'(0));
      check("rst_go", 32'(go), 32'(0));
      check("rst_miss", 32'(miss), 32'(0));
      check("rst_win", 32'(win), 32'(0));
      check("rst_cur", 32'(cur_player), 32'(0));
      check("rst_tile", 32'(tile_info), 32'(0));
      check("rst_winner", 32'(winner), 32'(0));

      for (int i = 0; i < 24; i++) cfg(1'b0, i, 1);
      cfg(1'b0, 1, 5);
      cfg(1'b0, 13, 2);
      cfg(1'b0, 0, 9);
      for (int i = 0; i < 12; i++) cfg(1'b1, i, 0);
      cfg(1'b1, 0, 1);
      cfg(1'b1, 3, 5);
      cfg(1'b1, 4, 7);
      cfg(1'b1, 2, 2);
      cfg(1'b1, 5, 9);

      start_game(2);
      check("start_ready", 32'(flip_ready), 32'(1));
      check("start_win", 32'(win), 32'(0));
      check("start_cur", 32'(cur_player), 32'(0));
      check("start_tile", 32'(tile_info), 32'(0));

      expect_evt(1'b1, 0, 1, 1'b0); flip(3);

      start_game(3);
      check("ign_start_tile", 32'(tile_info), 32'(1));
      check("ign_start_cur", 32'(cur_player), 32'(0));
      cfg(1'b0, 2, 7);

      expect_evt(1'b0, 1, 12, 1'b0); flip(4);
      expect_evt(1'b0, 0, 1, 1'b0);  flip(6);
      for (int i = 2; i <= 11; i++) begin
         expect_evt(1'b1, 0, i, 1'b0); flip(0);
      end
      expect_evt(1'b1, 0, 13, 1'b0); flip(2);
      for (int i = 14; i <= 23; i++) begin
         expect_evt(1'b1, 0, i, 1'b0); flip(0);
      end
      expect_evt(1'b1, 0, 0, 1'b1); flip(5);
      check("won_ready", 32'(flip_ready), 32'(0));

      @(negedge clk);
      flip_valid = 1'b1; flip_card = 4'(5);
      repeat (5) begin
         @(negedge clk);
         check("won_no_pulse", 32'(go | miss), 32'(0));
         check("won_hold", 32'(win), 32'(1));
         check("won_tile", 32'(tile_info), 32'(0));
      end
      flip_valid = 1'b0;

      start_game(7);
      check("restart_win", 32'(win), 32'(0));
      check("restart_ready", 32'(flip_ready), 32'(1));
      check("restart_tile", 32'(tile_info), 32'(0));
      expect_evt(1'b0, 1, 6, 1'b0);  flip(15);
      expect_evt(1'b0, 2, 12, 1'b0); flip(15);
      expect_evt(1'b0, 3, 18, 1'b0); flip(15);
      expect_evt(1'b0, 0, 0, 1'b0);  flip(15);

      @(negedge clk);
      flip_valid = 1'b1; flip_card = 4'(0);
      @(negedge clk);
      flip_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_go", 32'(go), 32'(0));
      check("midrst_miss", 32'(miss), 32'(0));
      check("midrst_ready", 32'(flip_ready), 32'(0));
      check("midrst_cur", 32'(cur_player), 32'(0));
      check("midrst_tile", 32'(tile_info), 32'(0));
      repeat (3) begin
         @(negedge clk);
         check("midrst_quiet", 32'(go | miss), 32'(0));
      end

      start_game(3);
      expect_evt(1'b1, 0, 1, 1'b0);  flip(3);
      expect_evt(1'b0, 1, 8, 1'b0);  flip(15);
      expect_evt(1'b0, 2, 16, 1'b0); flip(15);
      expect_evt(1'b0, 0, 1, 1'b0);  flip(15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
